// File: rtl/lsu_apb_master_pkg.sv
// Shared definitions for the LSU-to-APB bridge:
// load/store funct3 encodings, request legality and store lane steering.
package lsu_apb_master_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // A request is rejected without a bus transfer when both
  // directions are requested, funct3 is illegal or it is misaligned.
  function automatic logic req_bad(
    input logic       rd,
    input logic       wr,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic bad;
    bad = 1'b0;
    if (rd && wr) begin
      bad = 1'b1;
    end else if (wr) begin
      case (f3)
        F3_SB:   bad = 1'b0;
        F3_SH:   bad = a[0];
        F3_SW:   bad = |a;
        default: bad = 1'b1;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: bad = 1'b0;
        F3_LH, F3_LHU: bad = a[0];
        F3_LW:         bad = |a;
        default:       bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

  function automatic logic [3:0] st_strb(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic [3:0] s;
    case (f3)
      F3_SB:   s = 4'b0001 << a;
      F3_SH:   s = 4'b0011 << a;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] st_data(
    input logic [2:0]  f3,
    input logic [31:0] d
  );
    logic [31:0] w;
    case (f3)
      F3_SB:   w = {4{d[7:0]}};
      F3_SH:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lsu_apb_master_load_extend.sv
// Load lane select and sign/zero extension of the
// APB read word, purely combinational.
module load_extend
  import lsu_apb_master_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] lane;

  // Shift the addressed byte down to lane 0, then extend
  always_comb begin
    lane = word >> {off, 3'b000};
    case (funct3)
      F3_LB:   data = {{24{lane[7]}}, lane[7:0]};
      F3_LH:   data = {{16{lane[15]}}, lane[15:0]};
      F3_LBU:  data = {24'h0, lane[7:0]};
      F3_LHU:  data = {16'h0, lane[15:0]};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/lsu_apb_master.sv
// Bridges LSU load/store requests onto a single
// outstanding APB transfer with error and timeout reporting.
module lsu_apb_master
  import lsu_apb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [2:0]  funct3,
  output logic        mem_ready,
  output logic [31:0] load_data,
  output logic        mem_err,
  output logic [31:0] paddr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        req;
  logic        bad;
  logic        tmo;
  logic        err_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] cnt;
  logic [31:0] ext_data;

  assign req = mem_read_en | mem_write_en;
  assign bad = req_bad(mem_read_en, mem_write_en,
                       funct3, addr[1:0]);
  assign tmo = (TIMEOUT_CYCLES != 0) &&
               (cnt == 32'(TIMEOUT_CYCLES - 1));

  load_extend u_ext (
    .word   (prdata),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (ext_data)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (req) state_nx = bad ? S_DONE : S_SETUP;
      end
      S_SETUP: state_nx = S_ACCESS;
      S_ACCESS: begin
        if (pready || tmo) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Bus control and completion strobes decoded from state
  always_comb begin
    psel      = (state == S_SETUP) || (state == S_ACCESS);
    penable   = (state == S_ACCESS);
    mem_ready = (state == S_DONE);
    mem_err   = (state == S_DONE) && err_q;
  end

  // Request capture, wait counter, status and load result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      pwrite    <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      err_q     <= 1'b0;
      cnt       <= '0;
      load_data <= '0;
    end else begin
      if (state == S_IDLE && req) begin
        paddr  <= {addr[31:2], 2'b00};
        pwrite <= mem_write_en & ~mem_read_en;
        f3_q   <= funct3;
        off_q  <= addr[1:0];
        err_q  <= bad;
        if (mem_write_en) begin
          pstrb  <= st_strb(funct3, addr[1:0]);
          pwdata <= st_data(funct3, store_data);
        end else begin
          pstrb  <= 4'b0000;
          pwdata <= '0;
        end
      end
      if (state == S_SETUP) cnt <= '0;
      if (state == S_ACCESS) begin
        cnt <= cnt + 32'd1;
        if (pready) begin
          err_q <= pslverr;
          if (!pwrite && !pslverr) load_data <= ext_data;
        end else if (tmo) begin
          err_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_apb_master.sv
// Randomised scoreboard bench for lsu_apb_master
// with an APB completer model and a transaction-level reference.
module tb_lsu_apb_master;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read_en = 1'b0;
  logic        mem_write_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic [2:0]  funct3 = '0;
  logic        mem_ready;
  logic [31:0] load_data;
  logic        mem_err;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  lsu_apb_master #(.TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .addr         (addr),
    .store_data   (store_data),
    .funct3       (funct3),
    .mem_ready    (mem_ready),
    .load_data    (load_data),
    .mem_err      (mem_err),
    .paddr        (paddr),
    .psel         (psel),
    .penable      (penable),
    .pwrite       (pwrite),
    .pwdata       (pwdata),
    .pstrb        (pstrb),
    .prdata       (prdata),
    .pready       (pready),
    .pslverr      (pslverr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          err;
    logic [31:0] ld;
    int          lat;
    int          start;
    bit          apb;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    bit          pwrite;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model_ld = '0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cur_w = 0;
  bit          cur_err = 0;
  logic [31:0] cur_rd = '0;
  bit          no_sb = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: what the transaction should produce, from size/offset rules
  function automatic exp_t model(bit rd, bit wr, logic [31:0] a,
                                 logic [31:0] sd, logic [2:0] f3,
                                 int w, bit se, logic [31:0] rdat);
    exp_t e;
    int sz;
    bit ill;
    bit tmo;
    logic [31:0] b;
    ill = 0;
    sz = 0;
    if (rd && wr) ill = 1;
    else if (wr) begin
      if (f3 == 0) sz = 1;
      else if (f3 == 1) sz = 2;
      else if (f3 == 2) sz = 4;
      else ill = 1;
    end else begin
      if (f3 == 0 || f3 == 4) sz = 1;
      else if (f3 == 1 || f3 == 5) sz = 2;
      else if (f3 == 2) sz = 4;
      else ill = 1;
    end
    if (!ill && (a % sz) != 0) ill = 1;
    tmo = !ill && (w >= T);
    e.apb = !ill;
    e.paddr = a & 32'hFFFF_FFFC;
    e.pwrite = wr;
    e.pstrb = 4'b0000;
    e.pwdata = '0;
    if (wr && sz == 1) e.pwdata = {4{sd[7:0]}};
    if (wr && sz == 2) e.pwdata = {2{sd[15:0]}};
    if (wr && sz == 4) e.pwdata = sd;
    if (wr) e.pstrb = 4'(((1 << sz) - 1) << (a % 4));
    e.err = ill || tmo || se;
    e.lat = ill ? 1 : (tmo ? 2 + T : 3 + w);
    if (rd && !e.err) begin
      b = rdat >> (8 * (a % 4));
      if (f3 == 0) model_ld = {{24{b[7]}}, b[7:0]};
      else if (f3 == 4) model_ld = {24'h0, b[7:0]};
      else if (f3 == 1) model_ld = {{16{b[15]}}, b[15:0]};
      else if (f3 == 5) model_ld = {16'h0, b[15:0]};
      else model_ld = rdat;
    end
    e.ld = model_ld;
    e.start = 0;
    return e;
  endfunction

  // APB completer: w wait states, then pready with chosen response
  initial begin
    int acc;
    acc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (psel && penable) begin
        pready = (acc == cur_w);
        pslverr = cur_err && (acc == cur_w);
        prdata = (acc == cur_w) ? cur_rd : $urandom;
        acc++;
      end else begin
        pready = 1'b0;
        pslverr = 1'b0;
        acc = 0;
      end
    end
  end

  // Monitor: checks SETUP contents and every completion against the queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (penable && !psel) chk("penable_wo_psel", 1, 0);
        if (psel && !penable && !no_sb) begin
          if (q.size() == 0 || !q[0].apb) begin
            chk("unexpected_psel", 1, 0);
          end else begin
            chk("paddr", paddr, q[0].paddr);
            chk("pwrite", pwrite, q[0].pwrite);
            chk("pstrb", pstrb, q[0].pstrb);
            if (q[0].pwrite) chk("pwdata", pwdata, q[0].pwdata);
          end
        end
        if (mem_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_mem_ready", 1, 0);
          end else begin
            e = q.pop_front();
            chk("mem_err", mem_err, e.err);
            chk("load_data", load_data, e.ld);
            chk("latency", cyc - e.start, e.lat);
          end
        end
      end
    end
  end

  task automatic do_req(bit rd, bit wr, logic [31:0] a,
                        logic [31:0] sd, logic [2:0] f3,
                        int w, bit se, logic [31:0] rdat);
    exp_t e;
    bit seen;
    @(posedge clk);
    #1;
    cur_w = w;
    cur_err = se;
    cur_rd = rdat;
    e = model(rd, wr, a, sd, f3, w, se, rdat);
    e.start = cyc;
    q.push_back(e);
    mem_read_en = rd;
    mem_write_en = wr;
    addr = a;
    store_data = sd;
    funct3 = f3;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_ready) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      chk("mem_ready_timeout", 0, 1);
      q.delete();
    end
    @(posedge clk);
    #1;
    mem_read_en = 0;
    mem_write_en = 0;
    addr = $urandom;
    store_data = $urandom;
    funct3 = 3'($urandom_range(0, 7));
  endtask

  initial begin
    bit seen;
    int r;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_pstrb", pstrb, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_load_data", load_data, 0);
    @(posedge clk);
    #1;
    rst = 0;

    do_req(1, 0, 32'h100, 0, 3'b010, 0, 0, 32'hDEADBEEF);
    do_req(1, 0, 32'h103, 0, 3'b000, 0, 0, 32'h80123456);
    do_req(1, 0, 32'h103, 0, 3'b100, 1, 0, 32'h80123456);
    do_req(0, 1, 32'h202, 32'h0000ABCD, 3'b001, 2, 0, 0);
    do_req(0, 1, 32'h001, 32'h12345678, 3'b010, 0, 0, 0);
    do_req(1, 0, 32'h010, 0, 3'b010, 0, 1, 32'h55555555);
    do_req(1, 0, 32'h100, 0, 3'b010, 10, 0, 32'h11111111);
    do_req(1, 1, 32'h100, 0, 3'b010, 0, 0, 32'h22222222);
    do_req(1, 0, 32'h100, 0, 3'b011, 0, 0, 32'h33333333);
    do_req(1, 0, 32'h102, 0, 3'b101, 3, 0, 32'hF00D8001);

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 15);
      do_req(r == 0 || r < 8, r == 0 || r >= 8,
             $urandom, $urandom, 3'($urandom_range(0, 7)),
             $urandom_range(0, 5), ($urandom_range(0, 7) == 0),
             $urandom);
    end

    // Reset in the middle of an ACCESS phase abandons the transfer
    no_sb = 1;
    @(posedge clk);
    #1;
    cur_w = 1000;
    cur_err = 0;
    mem_read_en = 1;
    addr = 32'h40;
    funct3 = 3'b010;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (psel && penable) begin
        seen = 1;
        break;
      end
    end
    chk("reach_access", seen, 1);
    rst = 1;
    #1;
    chk("rst_mid_psel", psel, 0);
    chk("rst_mid_penable", penable, 0);
    chk("rst_mid_paddr", paddr, 0);
    model_ld = '0;
    @(posedge clk);
    #1;
    rst = 0;
    mem_read_en = 0;
    no_sb = 0;
    repeat (8) @(negedge clk);
    chk("rst_mid_load_data", load_data, 0);
    do_req(0, 1, 32'h33, 32'h000000A5, 3'b000, 0, 0, 0);
    do_req(1, 0, 32'h40, 0, 3'b010, 1, 0, 32'hCAFEF00D);
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
